// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable raster timing generator with a Wishbone control/status slave
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CLK_DIV  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb__adr,
    input  logic [31:0] wb__dat_w,
    output logic [31:0] wb__dat_r,
    input  logic [3:0]  sel,
    input  logic        wb__cyc,
    input  logic        wb__stb,
    input  logic        wb__we,
    output logic        wb__ack,
    output logic        pix_en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic        irq
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic [31:0]   fcnt_q, fcnt_d, dat_r_q, dat_r_d, rdata;
    logic          live_q, en_q, en_d, irq_en_q, irq_en_d, pend_q, pend_d, ack_q, ack_d;
    logic          run, x_last, y_last, wrap, ev, hs, vs, in_vb, req, wr, wr_ctrl, w1c;
    logic          unused_ok;

    assign unused_ok = ^{wb__adr[31:4], wb__adr[1:0], wb__dat_w[31:2], sel[3:1]};

    // Raster counters, sync decode, register file next-state and Wishbone handshake
    always_comb begin
        run         = en_q & live_q;
        pix_en      = run & (div_q == DW'(CLK_DIV - 1));
        x_last      = x_q == 11'(H_TOTAL - 1);
        y_last      = y_q == 11'(V_TOTAL - 1);
        wrap        = pix_en & x_last & y_last;
        ev          = pix_en & (x_q == 11'd0) & (y_q == 11'(V_ACTIVE));
        div_d       = (!run || pix_en) ? '0 : div_q + DW'(1);
        x_d         = !run ? '0 : pix_en ? (x_last ? '0 : x_q + 11'd1) : x_q;
        y_d         = !run ? '0 : (pix_en & x_last) ? (y_last ? '0 : y_q + 11'd1) : y_q;
        x           = run ? x_q : '0;
        y           = run ? y_q : '0;
        de          = run & (x_q < 11'(H_ACTIVE)) & (y_q < 11'(V_ACTIVE));
        hs          = run & (x_q >= 11'(H_ACTIVE + H_FP)) & (x_q < 11'(H_ACTIVE + H_FP + H_SYNC));
        vs          = run & (y_q >= 11'(V_ACTIVE + V_FP)) & (y_q < 11'(V_ACTIVE + V_FP + V_SYNC));
        hsync       = SYNC_POL ? hs : ~hs;
        vsync       = SYNC_POL ? vs : ~vs;
        frame_start = pix_en & (x_q == 11'd0) & (y_q == 11'd0);
        in_vb       = run & (y_q >= 11'(V_ACTIVE));
        wb__ack     = ack_q & wb__cyc & wb__stb;
        req         = wb__cyc & wb__stb & ~ack_q;
        wr          = wb__ack & wb__we & sel[0];
        wr_ctrl     = wr & (wb__adr[3:2] == 2'd0);
        w1c         = wr & (wb__adr[3:2] == 2'd1) & wb__dat_w[0];
        en_d        = wr_ctrl ? wb__dat_w[0] : en_q;
        irq_en_d    = wr_ctrl ? wb__dat_w[1] : irq_en_q;
        pend_d      = ev | (pend_q & ~w1c);
        fcnt_d      = fcnt_q + {31'd0, wrap};
        rdata       = wb__adr[3:2] == 2'd0 ? {30'd0, irq_en_q, en_q}
                    : wb__adr[3:2] == 2'd1 ? {30'd0, in_vb, pend_q}
                    : wb__adr[3:2] == 2'd2 ? fcnt_q
                    : {5'd0, y, 5'd0, x};
        dat_r_d     = req ? rdata : dat_r_q;
        ack_d       = req;
        irq         = pend_q & irq_en_q;
        wb__dat_r   = dat_r_q;
    end

    // State registers; live_q holds counting off for the clock reset is released on
    always_ff @(posedge clk) begin
        if (reset) begin
            live_q   <= 1'b0;
            en_q     <= 1'b1;
            irq_en_q <= 1'b0;
            pend_q   <= 1'b0;
            fcnt_q   <= '0;
            div_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ack_q    <= 1'b0;
            dat_r_q  <= '0;
        end else begin
            live_q   <= 1'b1;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            pend_q   <= pend_d;
            fcnt_q   <= fcnt_d;
            div_q    <= div_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ack_q    <= ack_d;
            dat_r_q  <= dat_r_d;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized bench checking the raster and register slave against a frame-arithmetic model
module tb_vga_timing_gen;
    localparam int HA = 16, HFP = 2, HS = 3, HBP = 3, HT = HA + HFP + HS + HBP;
    localparam int VA = 10, VFP = 2, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
    localparam int FT = HT * VT;

    logic        clk = 1'b0, reset = 1'b1;
    logic [31:0] adr = '0, dat_w = '0, dat_r, dat_r4;
    logic [3:0]  sel = '0, z4 = '0;
    logic [31:0] z32 = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, z1 = 1'b0;
    logic        ack, pix_en, hsync, vsync, de, fs, irq;
    logic        ack4, pe4, hs4, vs4, de4, fs4, irq4;
    logic [10:0] x, y, x4, y4;
    logic [26:0] v1, v4;
    int          total = 0, bad = 0;

    bit          m_live = 0, m_en = 1, m_irqen = 0, m_pend = 0, m_ack = 0;
    int unsigned m_fcnt = 0;
    logic [31:0] m_dat = '0;
    int          ticks = 0, t4 = 0;

    assign v1 = {pix_en, hsync, vsync, de, fs, x, y};
    assign v4 = {pe4, hs4, vs4, de4, fs4, x4, y4};

    always #5 clk = ~clk;

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                     .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                     .SYNC_POL(1'b0), .CLK_DIV(1)) dut (
        .clk(clk), .reset(reset), .wb__adr(adr), .wb__dat_w(dat_w), .wb__dat_r(dat_r),
        .sel(sel), .wb__cyc(cyc), .wb__stb(stb), .wb__we(we), .wb__ack(ack),
        .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .frame_start(fs), .irq(irq));

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
                     .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
                     .SYNC_POL(1'b1), .CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .wb__adr(z32), .wb__dat_w(z32), .wb__dat_r(dat_r4),
        .sel(z4), .wb__cyc(z1), .wb__stb(z1), .wb__we(z1), .wb__ack(ack4),
        .pix_en(pe4), .hsync(hs4), .vsync(vs4), .de(de4), .x(x4), .y(y4),
        .frame_start(fs4), .irq(irq4));

    // Expected {pix_en, hsync, vsync, de, frame_start, x, y} from the clock count since counting began
    function automatic logic [26:0] vid(bit run, int t, int div, bit pol);
        int n, px, py;
        bit pe, h, v;
        if (!run) return {1'b0, !pol, !pol, 1'b0, 1'b0, 22'd0};
        n  = t / div;
        px = n % HT;
        py = (n / HT) % VT;
        pe = (t % div) == div - 1;
        h  = px >= HA + HFP && px < HA + HFP + HS;
        v  = py >= VA + VFP && py < VA + VFP + VS;
        return {pe, pol ? h : !h, pol ? v : !v, px < HA && py < VA, pe && px == 0 && py == 0, 11'(px), 11'(py)};
    endfunction

    // Reference model: pixel position is the clock count since enable, registers follow the bus rules
    always @(posedge clk) begin
        bit run_b, ev, wrap, req, wr;
        int px, py;
        logic [31:0] rd;
        run_b = m_live && m_en;
        px    = ticks % HT;
        py    = (ticks / HT) % VT;
        ev    = run_b && px == 0 && py == VA;
        wrap  = run_b && px == HT - 1 && py == VT - 1;
        req   = cyc && stb && !m_ack;
        wr    = m_ack && cyc && stb && we && sel[0];
        case (adr[3:2])
            2'd0: rd = {30'd0, m_irqen, m_en};
            2'd1: rd = {30'd0, run_b && py >= VA, m_pend};
            2'd2: rd = m_fcnt;
            default: rd = run_b ? {5'd0, 11'(py), 5'd0, 11'(px)} : 32'd0;
        endcase
        if (reset) begin
            m_live = 0; m_en = 1; m_irqen = 0; m_pend = 0; m_ack = 0;
            m_fcnt = 0; m_dat = '0; ticks = 0; t4 = 0;
        end else begin
            if (req) m_dat = rd;
            m_pend = ev || (m_pend && !(wr && adr[3:2] == 2'd1 && dat_w[0]));
            if (wr && adr[3:2] == 2'd0) begin
                m_en    = dat_w[0];
                m_irqen = dat_w[1];
            end
            if (wrap) m_fcnt++;
            ticks  = run_b ? ticks + 1 : 0;
            t4     = m_live ? t4 + 1 : 0;
            m_live = 1;
            m_ack  = req;
        end
    end

    task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                           output logic got_ack, output logic [31:0] got_dat);
        adr = {28'($urandom), a, 2'b00};
        dat_w = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        got_ack = ack;
        got_dat = dat_r;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (v1 !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 22'd0}) begin
            bad++; $display("FAIL reset_video: got %h want %h", v1, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 22'd0});
        end
        total++;
        if (v4 !== 27'd0) begin bad++; $display("FAIL reset_video4: got %h want 0", v4); end
        total++;
        if ({irq, ack, dat_r} !== 34'd0) begin
            bad++; $display("FAIL reset_bus: irq=%b ack=%b dat_r=%h want 0 0 0", irq, ack, dat_r);
        end
        reset = 1'b0;
    endtask

    task automatic test_counting(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (v1 !== vid(m_live && m_en, ticks, 1, 1'b0)) begin
                bad++; $display("FAIL count: got %h want %h tick=%0d", v1, vid(m_live && m_en, ticks, 1, 1'b0), ticks);
            end
            total++;
            if (irq !== (m_pend && m_irqen)) begin bad++; $display("FAIL count_irq: got %b want %b", irq, m_pend && m_irqen); end
        end
    endtask

    task automatic test_clk_div(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if (v4 !== vid(m_live, t4, 4, 1'b1)) begin
                bad++; $display("FAIL clkdiv: got %h want %h tick=%0d", v4, vid(m_live, t4, 4, 1'b1), t4);
            end
        end
    endtask

    task automatic test_wb;
        logic a1, a2;
        logic [31:0] d;
        wb_xfer(2'd0, 1'b0, 32'd0, 4'hf, a1, d);
        total++;
        if (a1 !== 1'b1 || d !== 32'd1) begin bad++; $display("FAIL ctrl_read: ack=%b dat=%h want 1 00000001", a1, d); end
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, HT)) @(negedge clk);
            wb_xfer(2'($urandom), 1'b0, 32'd0, 4'hf, a1, d);
            total++;
            if (a1 !== 1'b1 || d !== m_dat) begin bad++; $display("FAIL rand_read: ack=%b dat=%h want 1 %h", a1, d, m_dat); end
        end
        repeat ($urandom_range(1, HT)) @(negedge clk);
        adr = 32'hc; we = 1'b0; sel = 4'hf; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        a1 = ack; d = dat_r;
        @(negedge clk);
        a2 = ack;
        cyc = 1'b0; stb = 1'b0;
        total++;
        if (a1 !== 1'b1 || a2 !== 1'b0) begin bad++; $display("FAIL ack_single: got %b%b want 10", a1, a2); end
        total++;
        if (d !== m_dat) begin bad++; $display("FAIL pos_read: got %h want %h", d, m_dat); end
        adr = 32'h0; dat_w = 32'h0; we = 1'b1; sel = 4'h1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        #1 a1 = ack;
        @(negedge clk);
        a2 = ack;
        we = 1'b0;
        total++;
        if (a1 !== 1'b0 || a2 !== 1'b0) begin bad++; $display("FAIL abort_ack: got %b%b want 00", a1, a2); end
        total++;
        if (pix_en !== 1'b1) begin bad++; $display("FAIL abort_write: pix_en=%b want 1", pix_en); end
        wb_xfer(2'd0, 1'b1, 32'h0, 4'he, a1, d);
        wb_xfer(2'd0, 1'b0, 32'd0, 4'hf, a1, d);
        total++;
        if (d !== m_dat || d[0] !== 1'b1) begin bad++; $display("FAIL sel_gate: got %h want %h", d, m_dat); end
    endtask

    task automatic test_irq;
        logic a;
        logic [31:0] d;
        int i;
        wb_xfer(2'd0, 1'b1, 32'h3, 4'h1, a, d);
        for (i = 0; i < 2 * FT && ticks % FT != 0; i++) @(negedge clk);
        wb_xfer(2'd1, 1'b1, 32'h1, 4'h1, a, d);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear0: got %b want 0", irq); end
        for (i = 0; i < 2 * FT && ticks % FT != VA * HT; i++) @(negedge clk);
        total++;
        if (ticks % FT != VA * HT) begin bad++; $display("FAIL vblank_wait: got tick %0d want %0d", ticks % FT, VA * HT); end
        total++;
        if (irq !== 1'b0 || x !== 11'd0 || y !== 11'(VA)) begin
            bad++; $display("FAIL pre_vblank: irq=%b x=%0d y=%0d want 0 0 %0d", irq, x, y, VA);
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL vblank_irq: got %b want 1", irq); end
        wb_xfer(2'd1, 1'b0, 32'd0, 4'hf, a, d);
        total++;
        if (d !== 32'h3) begin bad++; $display("FAIL status_read: got %h want 00000003", d); end
        wb_xfer(2'd1, 1'b1, 32'h1, 4'h1, a, d);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL w1c: got %b want 0", irq); end
        for (i = 0; i < 2 * FT && ticks % FT != VA * HT - 1; i++) @(negedge clk);
        wb_xfer(2'd1, 1'b1, 32'h1, 4'h1, a, d);
        total++;
        if (irq !== 1'b1 || irq !== (m_pend && m_irqen)) begin bad++; $display("FAIL w1c_coincident: got %b want 1", irq); end
        wb_xfer(2'd0, 1'b1, 32'h1, 4'h1, a, d);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL irq_en_off: got %b want 0", irq); end
        wb_xfer(2'd1, 1'b0, 32'd0, 4'hf, a, d);
        total++;
        if (d !== m_dat || d[0] !== 1'b1) begin bad++; $display("FAIL pending_kept: got %h want %h", d, m_dat); end
    endtask

    task automatic test_disable;
        logic a;
        logic [31:0] d;
        int unsigned fc;
        int i;
        for (i = 0; i < 2 * FT && ticks % FT != (VA / 2) * HT + HA / 2; i++) @(negedge clk);
        wb_xfer(2'd0, 1'b1, 32'h0, 4'h1, a, d);
        for (i = 0; i < 5 + int'($urandom_range(0, 15)); i++) begin
            total++;
            if (v1 !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 22'd0}) begin
                bad++; $display("FAIL disabled: got %h want %h", v1, {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 22'd0});
            end
            @(negedge clk);
        end
        fc = m_fcnt;
        wb_xfer(2'd0, 1'b1, 32'h1, 4'h1, a, d);
        total++;
        if (v1 !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 22'd0}) begin
            bad++; $display("FAIL reenable: got %h want %h", v1, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 22'd0});
        end
        wb_xfer(2'd2, 1'b0, 32'd0, 4'hf, a, d);
        total++;
        if (d !== fc) begin bad++; $display("FAIL reenable_fcnt: got %0d want %0d", d, fc); end
        test_counting(HT * 2);
    endtask

    task automatic test_frame_cnt;
        logic a;
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3 * FT + 5) @(negedge clk);
        wb_xfer(2'd2, 1'b0, 32'd0, 4'hf, a, d);
        total++;
        if (d !== 32'd3 || d !== m_dat) begin bad++; $display("FAIL frame_cnt: got %0d want 3", d); end
    endtask

    task automatic test_reset_mid;
        logic a;
        logic [31:0] d;
        repeat ($urandom_range(HT, 3 * HT)) @(negedge clk);
        adr = 32'h8; we = 1'b0; sel = 4'hf; cyc = 1'b1; stb = 1'b1; reset = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        total++;
        if ({v1, irq, dat_r} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 22'd0, 1'b0, 32'd0}) begin
            bad++; $display("FAIL reset_mid: video=%h irq=%b dat_r=%h", v1, irq, dat_r);
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (v1 !== vid(m_live && m_en, ticks, 1, 1'b0)) begin
            bad++; $display("FAIL after_reset: got %h want %h", v1, vid(m_live && m_en, ticks, 1, 1'b0));
        end
        wb_xfer(2'd0, 1'b0, 32'd0, 4'hf, a, d);
        total++;
        if (d !== 32'd1) begin bad++; $display("FAIL ctrl_default: got %h want 00000001", d); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_counting(2 * FT + int'($urandom_range(0, HT)));
        test_clk_div(12 * HT + int'($urandom_range(0, 7)));
        test_wb();
        test_irq();
        test_disable();
        test_frame_cnt();
        test_reset_mid();
        test_clk_div(4 * HT);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Programmable raster timing generator feeding the graphics pipeline of `myip1`. Produces pixel-enable, hsync/vsync, data-enable and current pixel coordinates consumed by the pixel/colour stage that drives the VGA, DAC and DVI output pins. Exposes a small Wishbone register slave for enable, vblank interrupt and frame-count readback. Vblank interrupt drives one bit of `buf_irq`.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch/sync widths in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch/sync widths in lines
- `SYNC_POL`, 0, sync active level (0 = active-low for both hsync and vsync)
- `CLK_DIV`, 1, clocks per pixel (1..16)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `wb__adr`  in  32  Wishbone address; only bits [3:2] decoded
- `wb__dat_w`  in  32  write data
- `wb__dat_r`  out  32  read data
- `sel`  in  4  byte select; writes require sel[0] for CTRL/STATUS
- `wb__cyc`, `wb__stb`, `wb__we`  in  1 each  Wishbone cycle/strobe/write
- `wb__ack`  out  1  Wishbone acknowledge
- `pix_en`  out  1  pixel strobe; counters advance on clocks where high
- `hsync`, `vsync`  out  1 each  sync outputs, polarity per `SYNC_POL`
- `de`  out  1  active-video flag
- `x`, `y`  out  11 each  current pixel column/line
- `frame_start`  out  1  one-clock pulse at pixel (0,0)
- `irq`  out  1  vblank interrupt, level

## Operation
- H_TOTAL = sum of H params, V_TOTAL = sum of V params; both ≤ 2048 (11-bit counters).
- Divider counts 0..CLK_DIV-1 while enabled; `pix_en` high when divider = CLK_DIV-1 (constant 1 when CLK_DIV=1).
- On `pix_en`: `x` increments; at H_TOTAL-1 wraps to 0 and `y` increments; `y` wraps at V_TOTAL-1 to 0.
- `de` = x<H_ACTIVE && y<V_ACTIVE. hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). All derived from the same registered counters — `x`,`y`,`de`,syncs always describe the same pixel.
- Registers (adr[3:2]): 0 CTRL RW {bit1 irq_en, bit0 enable}, reset 0b01; 1 STATUS {bit1 in_vblank RO, bit0 pending W1C}; 2 FRAME_CNT RO 32b; 3 POS RO {5'b0, y, 5'b0, x}. Unused bits read 0.
- Enable=0: divider, x, y held at 0; `pix_en`, `de`, `frame_start` 0; syncs inactive. Clearing enable mid-frame resets counters on next clock. Re-enable starts at (0,0) with `frame_start` on first `pix_en`.
- `frame_start` pulses on the clock where `pix_en`=1 and counters are (0,0).
- Vblank event: `pix_en` with counters at (0, V_ACTIVE); sets pending. Event and W1C on same clock: pending stays 1. `irq` = pending & irq_en.
- FRAME_CNT increments on wrap from (H_TOTAL-1, V_TOTAL-1); wraps modulo 2^32; not incremented by re-enable.

## Timing
- Reset: x=y=0, divider 0, `pix_en`=0, `de`=0, syncs inactive, `frame_start`=0, `irq`=0, `wb__ack`=0, `wb__dat_r`=0, CTRL=0b01, pending=0, FRAME_CNT=0. Enable takes effect the clock after reset deasserts.
- Wishbone: `wb__ack` asserted exactly one clock after `cyc&stb` seen with ack low; held one clock; never asserted on consecutive clocks. Read data registered and valid with ack. Writes take effect on the ack clock. Dropping `cyc` before ack aborts: no ack, no write.
- CTRL write changes counter behaviour from the following clock.
- `irq` follows pending/irq_en with one clock latency from the event or write.

## Test plan
- Reset, defaults, CLK_DIV=1: x counts 0..799, y increments at x wrap; hsync low for x 656..751, vsync low for y 490..491; de high for x<640,y<480; frame_start every 420000 clocks.
- CLK_DIV=4: `pix_en` 1-in-4; x advances only on strobe; one line = 3200 clocks.
- Set irq_en, run to (0,480): pending=1, irq=1 next clock; W1C STATUS clears; W1C coincident with vblank event leaves pending=1.
- Run 3 frames, read FRAME_CNT=3; read POS mid-line matches x/y; ack single-cycle with dat_r valid; abort (cyc dropped) gives no ack.
- Clear enable at (300,200): next clock x=y=0, de=0, syncs inactive; re-enable: frame_start pulse at (0,0), FRAME_CNT unchanged.
- Assert reset mid-frame and mid-Wishbone read: all outputs to reset values next clock, no ack issued.
